// File: rtl/cnn_layer_accel_weight_seq_pkg.sv
// Shared types and helpers for the weight sequencer slice.
package cnn_layer_accel_weight_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned C_SEQ_LEN_DEFAULT = 5;
  localparam int unsigned C_TBL_LAT_DEFAULT = 1;
  localparam int unsigned C_CNT_W_DEFAULT   = 10;
  localparam int unsigned ADDR_W            = 3;

  // 2-bit gray increment: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray2_next(input logic [1:0] g);
    logic [1:0] n;
    case (g)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_weight_sequencer_if.sv
// Control/handshake bundle between the job controller and the weight sequencer.
interface cnn_layer_accel_weight_sequencer_if
  import cnn_layer_accel_weight_seq_pkg::*;
#(
  parameter int unsigned C_CNT_W = C_CNT_W_DEFAULT
);
  logic               start;
  logic               stall;
  logic [C_CNT_W-1:0] num_output_cols;
  logic [C_CNT_W-1:0] num_row_pass;
  logic [1:0]         gray_code;
  logic               sequence_selector;
  logic [ADDR_W-1:0]  seq_data_addr;
  logic               seq_valid;
  logic               wht_valid;
  logic               row_pass_end;
  logic               busy;
  logic               done;

  modport master (
    output start, stall, num_output_cols, num_row_pass,
    input  gray_code, sequence_selector, seq_data_addr, seq_valid,
           wht_valid, row_pass_end, busy, done
  );

  modport slave (
    input  start, stall, num_output_cols, num_row_pass,
    output gray_code, sequence_selector, seq_data_addr, seq_valid,
           wht_valid, row_pass_end, busy, done
  );
endinterface

// File: rtl/cnn_layer_accel_gray_cntr2.sv
// 2-bit gray counter with enable and synchronous clear.
module cnn_layer_accel_gray_cntr2
  import cnn_layer_accel_weight_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] gray
);

  // Clear has priority over advance
  always_ff @(posedge clk) begin
    if (rst || clr) gray <= 2'b00;
    else if (en)    gray <= gray2_next(gray);
  end

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Generates the gray/selector/addr stream for one kernel pass of the weight table.
module cnn_layer_accel_weight_sequencer
  import cnn_layer_accel_weight_seq_pkg::*;
#(
  parameter int unsigned C_SEQ_LEN = C_SEQ_LEN_DEFAULT,
  parameter int unsigned C_TBL_LAT = C_TBL_LAT_DEFAULT,
  parameter int unsigned C_CNT_W   = C_CNT_W_DEFAULT
)(
  input logic clk,
  input logic rst,
  cnn_layer_accel_weight_sequencer_if.slave bus
);

  localparam int unsigned DRAIN_W = (C_TBL_LAT > 1) ? $clog2(C_TBL_LAT) : 1;

  seq_state_e         state_q, state_d;
  logic [C_CNT_W-1:0] cols_m1_q, rows_m1_q, col_q, row_q;
  logic               sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [C_TBL_LAT-1:0] wht_pipe_q;
  logic [1:0]         gray;

  logic accept, zero_cnt, advance, last_addr, last_col, last_row, pass_end, job_end;

  // Stream control decode
  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.start;
    zero_cnt  = (bus.num_output_cols == '0) || (bus.num_row_pass == '0);
    advance   = (state_q == ST_RUN) && !bus.stall;
    last_addr = (addr_q == ADDR_W'(C_SEQ_LEN - 1));
    last_col  = (col_q == cols_m1_q);
    last_row  = (row_q == rows_m1_q);
    pass_end  = advance && !sel_q && last_addr && last_col;
    job_end   = pass_end && last_row;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = zero_cnt ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (job_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_W'(C_TBL_LAT - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Entry/selector/column/row counters; wrap back to the reset tuple at job end
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_m1_q <= '0;
      rows_m1_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      sel_q     <= 1'b1;
      addr_q    <= '0;
    end else if (accept) begin
      cols_m1_q <= bus.num_output_cols - C_CNT_W'(1);
      rows_m1_q <= bus.num_row_pass - C_CNT_W'(1);
      col_q     <= '0;
      row_q     <= '0;
      sel_q     <= 1'b1;
      addr_q    <= '0;
    end else if (job_end) begin
      col_q  <= '0;
      row_q  <= '0;
      sel_q  <= 1'b1;
      addr_q <= '0;
    end else if (advance) begin
      if (last_addr) begin
        addr_q <= '0;
        sel_q  <= ~sel_q;
        if (!sel_q) begin
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + C_CNT_W'(1);
          end else begin
            col_q <= col_q + C_CNT_W'(1);
          end
        end
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Drain cycle counter, only runs while draining
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_DRAIN) drain_q <= '0;
    else                            drain_q <= drain_q + DRAIN_W'(1);
  end

  // Delay line matching the table's registered latency
  always_ff @(posedge clk) begin
    if (rst) wht_pipe_q <= '0;
    else     wht_pipe_q <= (wht_pipe_q << 1) | C_TBL_LAT'(advance);
  end

  cnn_layer_accel_gray_cntr2 u_gray (
    .clk  (clk),
    .rst  (rst),
    .en   (pass_end),
    .clr  (accept || job_end),
    .gray (gray)
  );

  assign bus.gray_code         = gray;
  assign bus.sequence_selector = sel_q;
  assign bus.seq_data_addr     = addr_q;
  assign bus.seq_valid         = advance;
  assign bus.wht_valid         = wht_pipe_q[C_TBL_LAT-1];
  assign bus.row_pass_end      = pass_end;
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Randomized self-checking bench for the weight sequencer.
module tb_cnn_layer_accel_weight_sequencer;
  localparam int SEQ_LEN = 5;
  localparam int CNT_W   = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  cnn_layer_accel_weight_sequencer_if #(.C_CNT_W(CNT_W)) bus ();

  cnn_layer_accel_weight_sequencer #(
    .C_SEQ_LEN(SEQ_LEN), .C_TBL_LAT(1), .C_CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference: entry k of a job, gray phase follows row index mod 4 in gray order
  typedef struct { logic [5:0] tup; bit rpe; } ent_t;

  task automatic build(input int rows, input int cols, output ent_t q[$]);
    int g_tab[4] = '{0, 1, 3, 2};
    ent_t e;
    q = {};
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int s = 1; s >= 0; s--)
          for (int a = 0; a < SEQ_LEN; a++) begin
            e.tup = {2'(g_tab[r % 4]), 1'(s), 3'(a)};
            e.rpe = (s == 0) && (a == SEQ_LEN - 1) && (c == cols - 1);
            q.push_back(e);
          end
  endtask

  function automatic logic [5:0] dut_tup();
    return {bus.gray_code, bus.sequence_selector, bus.seq_data_addr};
  endfunction

  // Runs one job; stall_idx/stall_len force a stall burst, abort_at resets mid-run
  task automatic run_job(input int rows, input int cols, input int stall_pct, input bit junk,
                         input int stall_idx, input int stall_len, input int abort_at);
    ent_t q[$];
    int   n, idx, ph, forced;
    bit   st, prev_sv, exp_sv, fin;
    build(rows, cols, q);
    n = q.size();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_row_pass = CNT_W'(rows);
    bus.num_output_cols = CNT_W'(cols);
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; forced = 0; prev_sv = 0; fin = 0;
    ph = (n == 0) ? 1 : 0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      st = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
      if (ph == 0 && idx == stall_idx && forced < stall_len) begin
        st = 1'b1;
        forced++;
      end
      bus.stall = st;
      if (junk) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.num_output_cols = CNT_W'($urandom);
        bus.num_row_pass = CNT_W'($urandom);
      end
      if (ph == 0 && abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1; bus.stall = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tuple", 32'(dut_tup()), 32'h08);
        chk("abort_seq_valid", 32'(bus.seq_valid), 0);
        chk("abort_wht_valid", 32'(bus.wht_valid), 0);
        chk("abort_rpe", 32'(bus.row_pass_end), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 4; i++) begin
          chk("abort_done", 32'(bus.done), 0);
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
      exp_sv = (ph == 0) && !st;
      chk("seq_valid", 32'(bus.seq_valid), 32'(exp_sv));
      chk("wht_valid", 32'(bus.wht_valid), 32'(prev_sv));
      chk("busy", 32'(bus.busy), 1);
      chk("done", 32'(bus.done), 32'(ph == 2));
      chk("tuple", 32'(dut_tup()), (ph == 0) ? 32'(q[idx].tup) : 32'h08);
      chk("row_pass_end", 32'(bus.row_pass_end), 32'((ph == 0) && !st && q[idx].rpe));
      prev_sv = exp_sv;
      if (ph == 0) begin
        if (!st) idx++;
        if (idx == n) ph = 1;
      end else if (ph == 1) begin
        ph = 2;
      end else begin
        fin = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    chk("job_finished", 32'(fin), 1);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_wht", 32'(bus.wht_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.num_output_cols = '0;
    bus.num_row_pass = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tuple", 32'(dut_tup()), 32'h08);
    chk("rst_seq_valid", 32'(bus.seq_valid), 0);
    chk("rst_wht_valid", 32'(bus.wht_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    run_job(1, 2, 0, 0, -1, 0, -1);
    run_job(4, 1, 0, 0, -1, 0, -1);
    run_job(1, 1, 0, 0, 2, 3, -1);
    run_job(5, 0, 0, 0, -1, 0, -1);
    run_job(0, 3, 0, 0, -1, 0, -1);
    run_job(2, 2, 0, 1, -1, 0, -1);
    run_job(1, 1, 0, 0, -1, 0, -1);
    run_job(2, 2, 0, 0, -1, 0, 7);
    run_job(1, 2, 0, 0, -1, 0, -1);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 4), 30, 1, -1, 0, -1);
    run_job(1, 1023, 0, 0, -1, 0, -1);
    run_job(1023, 1, 5, 0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
